// File: rtl/ccc_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ccc_cfg_pkg
// Shared definitions for the CCC dynamic-configuration controller:
//   - ccc_state_e : controller FSM encoding (also exported on the debug port)
//   - CCC_CFG_WIDTH : default length of the CCC dynamic configuration chain
//   - *_OFF / *_W : bit offset and width of each field inside the chain word.
//     Bit 0 of the word is the first bit shifted into the CCC.
// ---------------------------------------------------------------------------
package ccc_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_UPDATE    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_READY     = 3'd4
  } ccc_state_e;

  localparam int CCC_CFG_WIDTH = 81;

  // Reference and feedback dividers
  localparam int FINDIV_OFF  = 0;   localparam int FINDIV_W  = 7;
  localparam int FBDIV_OFF   = 7;   localparam int FBDIV_W   = 7;
  // Output dividers for GLA/GLB/GLC
  localparam int OADIV_OFF   = 14;  localparam int OADIV_W   = 5;
  localparam int OBDIV_OFF   = 19;  localparam int OBDIV_W   = 5;
  localparam int OCDIV_OFF   = 24;  localparam int OCDIV_W   = 5;
  // Output source muxes
  localparam int OAMUX_OFF   = 29;  localparam int OAMUX_W   = 3;
  localparam int OBMUX_OFF   = 32;  localparam int OBMUX_W   = 3;
  localparam int OCMUX_OFF   = 35;  localparam int OCMUX_W   = 3;
  // Feedback path select and delay
  localparam int FBSEL_OFF   = 38;  localparam int FBSEL_W   = 2;
  localparam int DLY_OFF     = 40;  localparam int DLY_W     = 5;
  localparam int XDLYSEL_OFF = 45;  localparam int XDLYSEL_W = 1;
  // Per-output PLL bypass (A, B, C)
  localparam int BYPASS_OFF  = 46;  localparam int BYPASS_W  = 3;
  // Bits 49..80 hold output delay taps and reserved bits, passed through as-is.

endpackage

// File: rtl/ccc_dyncfg_ctrl_lock_filter.sv
// ---------------------------------------------------------------------------
// lock_filter
// Brings the asynchronous PLL lock into the FAB_CLK domain and qualifies it.
//   clk_i, rst_i    : block clock, async active-high reset
//   lock_i          : raw PLL lock (asynchronous)
//   clr_i           : holds the stable counter at zero
//   lock_sync_o     : lock after the 2-FF synchronizer
//   lock_drop_o     : synchronized lock will be low on the next cycle
//   lock_stable_o   : lock has been high LOCK_STABLE cycles as of next edge
// ---------------------------------------------------------------------------
module lock_filter #(
  parameter int LOCK_STABLE = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  input  logic clr_i,
  output logic lock_sync_o,
  output logic lock_drop_o,
  output logic lock_stable_o
);

  localparam int CW = $clog2(LOCK_STABLE + 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating count of consecutive synchronized-high cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !sync_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LOCK_STABLE)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= lock_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign lock_sync_o = sync_q;
  // The first stage already holds the value sync_q takes next, so decisions
  // registered off it land in the same cycle the synchronized lock changes.
  assign lock_drop_o = ~meta_q;
  // Requiring the next synchronized value to be high makes a loss coinciding
  // with the threshold keep the controller waiting.
  assign lock_stable_o = sync_q && meta_q && (cnt_q >= CW'(LOCK_STABLE - 1));

endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// ---------------------------------------------------------------------------
// ccc_dyncfg_ctrl
// Reprograms the CCC at run time: captures a configuration word, shifts it
// LSB-first into the CCC chain, strobes update, then waits for a stable PLL
// lock before flagging the clock as ready.
//   FAB_CLK, RESET   : block clock, async active-high reset
//   CFG_REQ/CFG_DATA : request and configuration word
//   CFG_ACK          : one-cycle pulse when CFG_DATA is captured
//   PLL_LOCK         : CCC lock (asynchronous)
//   SCLK/SDIN/SSHIFT/SUPDATE/MODE : CCC dynamic configuration interface
//   BUSY, CLK_READY, CFG_DONE, CFG_ERR : status
//   STATE_DBG        : current FSM state
//
// Handshake: CFG_REQ is a level held by the requester until it sees CFG_ACK.
// A request is accepted only when the controller is IDLE or READY; the word is
// captured on that edge and CFG_ACK is high for exactly the following cycle.
// Requests while BUSY are neither acknowledged nor captured.
// ---------------------------------------------------------------------------
module ccc_dyncfg_ctrl
  import ccc_cfg_pkg::*;
#(
  parameter int CFG_WIDTH    = CCC_CFG_WIDTH,
  parameter int SCLK_DIV     = 4,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 FAB_CLK,
  input  logic                 RESET,
  input  logic                 CFG_REQ,
  input  logic [CFG_WIDTH-1:0] CFG_DATA,
  output logic                 CFG_ACK,
  input  logic                 PLL_LOCK,
  output logic                 SCLK,
  output logic                 SDIN,
  output logic                 SSHIFT,
  output logic                 SUPDATE,
  output logic                 MODE,
  output logic                 BUSY,
  output logic                 CLK_READY,
  output logic                 CFG_DONE,
  output logic                 CFG_ERR,
  output ccc_state_e           STATE_DBG
);

  localparam int BIT_W = $clog2(CFG_WIDTH + 1);
  localparam int PH_W  = $clog2(2 * SCLK_DIV + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  ccc_state_e           state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CFG_WIDTH-1:0] shreg_q, shreg_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic sclk_q, sclk_d, sdin_q, sdin_d, sshift_q, sshift_d, supdate_q, supdate_d;
  logic mode_q, mode_d, busy_q, busy_d, rdy_q, rdy_d;
  logic ack_q, ack_d, done_q, done_d, err_q, err_d;

  logic lock_sync, lock_drop, lock_stable, lock_fall, stb_clr;

  // The stable count only means something while waiting for lock.
  assign stb_clr = (state_q != ST_WAIT_LOCK);

  lock_filter #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_filter (
    .clk_i        (FAB_CLK),
    .rst_i        (RESET),
    .lock_i       (PLL_LOCK),
    .clr_i        (stb_clr),
    .lock_sync_o  (lock_sync),
    .lock_drop_o  (lock_drop),
    .lock_stable_o(lock_stable)
  );

  assign lock_fall = lock_sync & lock_drop;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    sclk_d    = sclk_q;
    sdin_d    = sdin_q;
    sshift_d  = sshift_q;
    supdate_d = supdate_q;
    mode_d    = mode_q;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_READY: begin
        // A request beats a simultaneous lock loss in READY.
        if (CFG_REQ) begin
          state_d   = ST_SHIFT;
          ack_d     = 1'b1;
          sdin_d    = CFG_DATA[0];
          shreg_d   = {1'b0, CFG_DATA[CFG_WIDTH-1:1]};
          sclk_d    = 1'b0;
          sshift_d  = 1'b1;
          mode_d    = 1'b1;
          phase_d   = '0;
          bit_d     = '0;
        end else if (state_q == ST_READY && lock_fall) begin
          state_d = ST_WAIT_LOCK;
          tmo_d   = '0;
        end
      end

      ST_SHIFT: begin
        // Each bit: SCLK low for SCLK_DIV cycles, then high for SCLK_DIV.
        // SDIN only moves when SCLK drops, so it is settled at the rise.
        if (phase_q == PH_W'(SCLK_DIV - 1)) begin
          phase_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sclk_d = 1'b0;
            if (bit_d == BIT_W'(CFG_WIDTH)) begin
              state_d   = ST_UPDATE;
              sshift_d  = 1'b0;
              supdate_d = 1'b1;
            end else begin
              sdin_d  = shreg_q[0];
              shreg_d = {1'b0, shreg_q[CFG_WIDTH-1:1]};
            end
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_UPDATE: begin
        if (phase_q == PH_W'(2 * SCLK_DIV - 1)) begin
          phase_d   = '0;
          supdate_d = 1'b0;
          state_d   = ST_WAIT_LOCK;
          tmo_d     = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_stable) begin
          state_d = ST_READY;
          done_d  = 1'b1;
        end else if (tmo_q >= TMO_W'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (tmo_q != TMO_W'(LOCK_TIMEOUT)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_READY);
    rdy_d  = (state_d == ST_READY);
  end

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      sclk_q    <= 1'b0;
      sdin_q    <= 1'b0;
      sshift_q  <= 1'b0;
      supdate_q <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      tmo_q     <= tmo_d;
      sclk_q    <= sclk_d;
      sdin_q    <= sdin_d;
      sshift_q  <= sshift_d;
      supdate_q <= supdate_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign SCLK      = sclk_q;
  assign SDIN      = sdin_q;
  assign SSHIFT    = sshift_q;
  assign SUPDATE   = supdate_q;
  assign MODE      = mode_q;
  assign BUSY      = busy_q;
  assign CLK_READY = rdy_q;
  assign CFG_ACK   = ack_q;
  assign CFG_DONE  = done_q;
  assign CFG_ERR   = err_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_ccc_dyncfg_ctrl.sv
module tb_ccc_dyncfg_ctrl;
  import ccc_cfg_pkg::*;

  localparam int W  = 81;
  localparam int SD = 2;
  localparam int LS = 8;
  localparam int LT = 100;

  logic         FAB_CLK = 1'b0;
  logic         RESET;
  logic         CFG_REQ;
  logic [W-1:0] CFG_DATA;
  logic         PLL_LOCK;
  logic         CFG_ACK, SCLK, SDIN, SSHIFT, SUPDATE, MODE, BUSY;
  logic         CLK_READY, CFG_DONE, CFG_ERR;
  ccc_state_e   STATE_DBG;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 FAB_CLK = ~FAB_CLK;

  ccc_dyncfg_ctrl #(
    .CFG_WIDTH(W), .SCLK_DIV(SD), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
  ) dut (
    .FAB_CLK(FAB_CLK), .RESET(RESET), .CFG_REQ(CFG_REQ), .CFG_DATA(CFG_DATA),
    .CFG_ACK(CFG_ACK), .PLL_LOCK(PLL_LOCK), .SCLK(SCLK), .SDIN(SDIN),
    .SSHIFT(SSHIFT), .SUPDATE(SUPDATE), .MODE(MODE), .BUSY(BUSY),
    .CLK_READY(CLK_READY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR),
    .STATE_DBG(STATE_DBG)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic test_reset();
    logic [9:0] outs;
    RESET = 1'b1; CFG_REQ = 1'b0; CFG_DATA = '0; PLL_LOCK = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    repeat (10) tick();
    outs = {SCLK, SDIN, SSHIFT, SUPDATE, MODE, BUSY, CLK_READY, CFG_ACK, CFG_DONE, CFG_ERR};
    total++;
    if (outs !== 10'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", outs, 10'b0);
    end
    total++;
    if (BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", BUSY);
    end
    total++;
    if (STATE_DBG !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", STATE_DBG, ST_IDLE);
    end
  endtask

  // Raises CFG_REQ and checks the acknowledge cycle. CFG_REQ is left high.
  task automatic do_request(input logic [W-1:0] data, input string tag);
    logic [5:0] v;
    CFG_DATA = data;
    CFG_REQ  = 1'b1;
    tick();
    v = {CFG_ACK, SSHIFT, SCLK, MODE, BUSY, CLK_READY};
    total++;
    if (v !== 6'b110110) begin
      bad++; $display("FAIL %s_ack {ack,sshift,sclk,mode,busy,rdy}: got %b want 110110", tag, v);
    end
    total++;
    if (STATE_DBG !== ST_SHIFT) begin
      bad++; $display("FAIL %s_ack_state: got %0d want %0d", tag, STATE_DBG, ST_SHIFT);
    end
    total++;
    if (SDIN !== data[0]) begin
      bad++; $display("FAIL %s_first_sdin: got %b want %b", tag, SDIN, data[0]);
    end
  endtask

  // Follows a shift through to the end of UPDATE; returns on the first cycle
  // in WAIT_LOCK. hold>0 keeps CFG_REQ asserted (with different data) that
  // many cycles into the shift to show busy requests are ignored.
  task automatic run_shift(input logic [W-1:0] data, input int hold, input string tag);
    int   sh_cnt, upd_cnt, rises, bit_err, chg_err, acks, upd_act;
    logic prev_sclk, prev_sdin, saw_upd, finished;
    sh_cnt = SSHIFT ? 1 : 0;
    upd_cnt = 0; rises = 0; bit_err = 0; chg_err = 0; acks = 0; upd_act = 0;
    saw_upd = 1'b0; finished = 1'b0;
    prev_sclk = SCLK; prev_sdin = SDIN;
    if (hold == 0) CFG_REQ = 1'b0;
    else CFG_DATA = ~data;
    for (int c = 0; c < 600 && !finished; c++) begin
      if (c == hold) CFG_REQ = 1'b0;
      tick();
      if (CFG_ACK) acks++;
      if (SSHIFT) sh_cnt++;
      if (SUPDATE) begin
        upd_cnt++; saw_upd = 1'b1;
        if (SCLK || SSHIFT) upd_act++;
      end
      if (SCLK && !prev_sclk) begin
        if (rises < W && SDIN !== data[rises]) bit_err++;
        rises++;
      end
      if (SDIN !== prev_sdin && !(prev_sclk && !SCLK)) chg_err++;
      if (saw_upd && !SUPDATE) finished = 1'b1;
      prev_sclk = SCLK; prev_sdin = SDIN;
    end
    total++;
    if (finished !== 1'b1) begin
      bad++; $display("FAIL %s_complete: got %b want 1 within 600 cycles", tag, finished);
    end
    total++;
    if (sh_cnt != W * 2 * SD) begin
      bad++; $display("FAIL %s_sshift_cycles: got %0d want %0d", tag, sh_cnt, W * 2 * SD);
    end
    total++;
    if (rises != W) begin
      bad++; $display("FAIL %s_sclk_rises: got %0d want %0d", tag, rises, W);
    end
    total++;
    if (bit_err != 0) begin
      bad++; $display("FAIL %s_sdin_bits: got %0d wrong bits want 0", tag, bit_err);
    end
    total++;
    if (chg_err != 0) begin
      bad++; $display("FAIL %s_sdin_stability: got %0d bad changes want 0", tag, chg_err);
    end
    total++;
    if (upd_cnt != 2 * SD) begin
      bad++; $display("FAIL %s_supdate_cycles: got %0d want %0d", tag, upd_cnt, 2 * SD);
    end
    total++;
    if (upd_act != 0) begin
      bad++; $display("FAIL %s_update_quiet: got %0d cycles with sclk/sshift want 0", tag, upd_act);
    end
    total++;
    if (acks != 0) begin
      bad++; $display("FAIL %s_extra_ack: got %0d want 0", tag, acks);
    end
    total++;
    if (STATE_DBG !== ST_WAIT_LOCK || BUSY !== 1'b1) begin
      bad++; $display("FAIL %s_wait_lock: got state=%0d busy=%b want state=%0d busy=1",
                      tag, STATE_DBG, BUSY, ST_WAIT_LOCK);
    end
  endtask

  // Called on the first WAIT_LOCK cycle; lock rises now.
  task automatic test_lock();
    int   first_done;
    logic rdy_at, busy_at, done_after;
    first_done = -1; rdy_at = 1'b0; busy_at = 1'b1; done_after = 1'b1;
    PLL_LOCK = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (first_done > 0 && k == first_done + 1) begin
        done_after = CFG_DONE;
        break;
      end
      if (CFG_DONE && first_done < 0) begin
        first_done = k; rdy_at = CLK_READY; busy_at = BUSY;
      end
    end
    total++;
    if (first_done != LS + 2) begin
      bad++; $display("FAIL lock_done_latency: got %0d want %0d", first_done, LS + 2);
    end
    total++;
    if (rdy_at !== 1'b1 || busy_at !== 1'b0) begin
      bad++; $display("FAIL lock_ready_flags: got rdy=%b busy=%b want rdy=1 busy=0", rdy_at, busy_at);
    end
    total++;
    if (done_after !== 1'b0) begin
      bad++; $display("FAIL lock_done_pulse: got %b after pulse want 0", done_after);
    end
  endtask

  task automatic test_lock_drop();
    int first_done, activity;
    first_done = -1; activity = 0;
    PLL_LOCK = 1'b0;
    tick();
    total++;
    if (CLK_READY !== 1'b1) begin
      bad++; $display("FAIL drop_ready_1cyc: got %b want 1", CLK_READY);
    end
    PLL_LOCK = 1'b1;
    tick();
    total++;
    if (CLK_READY !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL drop_ready_2cyc: got rdy=%b busy=%b want rdy=0 busy=1", CLK_READY, BUSY);
    end
    for (int k = 3; k <= 40 && first_done < 0; k++) begin
      tick();
      if (SCLK || SSHIFT || SUPDATE) activity++;
      if (CFG_DONE) first_done = k;
    end
    total++;
    if (first_done != LS + 3) begin
      bad++; $display("FAIL drop_relock_done: got cycle %0d want %0d", first_done, LS + 3);
    end
    total++;
    if (activity != 0 || CLK_READY !== 1'b1) begin
      bad++; $display("FAIL drop_no_reshift: got activity=%0d rdy=%b want 0 and 1", activity, CLK_READY);
    end
  endtask

  // Lock loss and request collide in READY, then lock never returns.
  task automatic test_req_vs_loss_timeout(input logic [W-1:0] data);
    int   first_err;
    logic [3:0] v;
    logic err_after;
    first_err = -1; v = '0; err_after = 1'b1;
    PLL_LOCK = 1'b0;
    tick();
    do_request(data, "collide");
    run_shift(data, 20, "busyreq");
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (first_err > 0) begin
        err_after = CFG_ERR;
        break;
      end
      if (CFG_ERR) begin
        first_err = k;
        v = {MODE, CLK_READY, BUSY, STATE_DBG == ST_IDLE};
      end
    end
    total++;
    if (first_err != LT) begin
      bad++; $display("FAIL timeout_latency: got %0d want %0d", first_err, LT);
    end
    total++;
    if (v !== 4'b1001) begin
      bad++; $display("FAIL timeout_flags {mode,rdy,busy,idle}: got %b want 1001", v);
    end
    total++;
    if (err_after !== 1'b0) begin
      bad++; $display("FAIL timeout_err_pulse: got %b want 0", err_after);
    end
  endtask

  task automatic test_reset_midshift(input logic [W-1:0] d_abort, input logic [W-1:0] d_new);
    int   rises;
    logic prev_sclk;
    logic [10:0] outs;
    rises = 0;
    PLL_LOCK = 1'b0;
    do_request(d_abort, "abort");
    CFG_REQ = 1'b0;
    prev_sclk = SCLK;
    for (int c = 0; c < 400 && rises < 40; c++) begin
      tick();
      if (SCLK && !prev_sclk) rises++;
      prev_sclk = SCLK;
    end
    tick(); tick();
    total++;
    if (SSHIFT !== 1'b1 || rises != 40) begin
      bad++; $display("FAIL abort_midshift: got sshift=%b rises=%0d want 1 and 40", SSHIFT, rises);
    end
    RESET = 1'b1;
    #1;
    outs = {SCLK, SDIN, SSHIFT, SUPDATE, MODE, BUSY, CLK_READY, CFG_ACK, CFG_DONE, CFG_ERR,
            STATE_DBG != ST_IDLE};
    total++;
    if (outs !== 11'b0) begin
      bad++; $display("FAIL abort_reset_outputs: got %b want %b", outs, 11'b0);
    end
    tick();
    RESET = 1'b0;
    tick();
    do_request(d_new, "after_abort");
    run_shift(d_new, 0, "after_abort");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    logic [W-1:0] d1, d2, d3, d4;
    d1 = 81'h1_2345_6789_ABCD_EF01_2345;
    d2 = 81'h1_A5A5_5A5A_0F0F_F0F0_3C3C;
    d3 = 81'h0_0000_FFFF_0000_FFFF_8001;
    d4 = 81'h0_DEAD_BEEF_0123_4567_89AB;

    test_reset();
    do_request(d1, "first");
    run_shift(d1, 0, "first");
    test_lock();
    test_lock_drop();
    test_req_vs_loss_timeout(d2);
    test_reset_midshift(d3, d4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
